// File: rtl/neo_f0_sync.sv
`timescale 1ns/1ps
// neo_f0_sync
// F0 system I/O block for the NeoGeo model. It decodes 68k writes in the
// $38xxx1 bit-write space into slot, LED and RTC-control registers, and
// serves the DIP-switch and status reads. A small command engine shifts a
// 4-bit uPD4990 command out LSB first and then pulses STROBE, so the BIOS
// does not have to bit-bang the RTC pins.
module neo_f0_sync #(
  parameter int NUM_SLOTS = 6,
  parameter int RTC_DIV   = 12
) (
  input  logic                 CLK_24M,
  input  logic                 RESET,
  input  logic                 nDIPRD0,
  input  logic                 nDIPRD1,
  input  logic                 nBITWD0,
  input  logic [7:4]           M68K_ADDR,
  input  logic [7:0]           M68K_DATA_IN,
  output logic [7:0]           M68K_DATA_OUT,
  output logic                 M68K_DATA_OE,
  input  logic [7:0]           DIPSW,
  input  logic                 SYSTEMB,
  output logic [NUM_SLOTS-1:0] nSLOT,
  output logic [2:0]           SLOT_SEL,
  output logic [2:0]           LED_LATCH,
  output logic [7:0]           LED_DATA,
  input  logic                 RTC_DOUT,
  input  logic                 RTC_TP,
  output logic                 RTC_DIN,
  output logic                 RTC_CLK,
  output logic                 RTC_STROBE,
  output logic                 RTC_BUSY
);

  // The divider counts 0 .. RTC_DIV-1 inside every serial phase.
  localparam int               DIV_W    = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RTC_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BIT_LO = 2'd1,
    ST_BIT_HI = 2'd2,
    ST_STROBE = 2'd3
  } rtc_state_t;

  // One-hot write decode positions
  localparam int W_SLOTS = 0;
  localparam int W_LATCH = 1;
  localparam int W_LDATA = 2;
  localparam int W_MAN   = 3;
  localparam int W_CMD   = 4;

  // Write strobe synchroniser and edge detector
  logic wr_sync1_r;
  logic wr_sync2_r;
  logic wr_prev_r;
  logic wr_s;

  // Write decode
  logic [4:0] dec_s;
  logic [4:0] wr_vec_s;

  // Plain registers
  logic [2:0] slots_r;
  logic [2:0] led_latch_r;
  logic [7:0] led_data_r;

  // RTC engine state
  rtc_state_t       state_r;
  logic [2:0]       man_r;
  logic [3:0]       cmd_r;
  logic [1:0]       bit_idx_r;
  logic [DIV_W-1:0] div_r;
  logic             din_r;
  logic             clk_r;
  logic             strobe_r;
  logic             busy_r;

  // Read path and slot decode
  logic [7:0]           rd_data_s;
  logic                 rd_oe_s;
  logic [NUM_SLOTS-1:0] nslot_s;

  // Bring the asynchronous write strobe into the clock domain; idle level is 1.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      wr_sync1_r <= 1'b1;
      wr_sync2_r <= 1'b1;
      wr_prev_r  <= 1'b1;
    end else begin
      wr_sync1_r <= nBITWD0;
      wr_sync2_r <= wr_sync1_r;
      wr_prev_r  <= wr_sync2_r;
    end
  end

  // A falling edge of the synchronised strobe is a single-cycle write pulse,
  // so a strobe held low for many cycles still yields exactly one write.
  assign wr_s = wr_prev_r & ~wr_sync2_r;

  // Map address bits [6:4] onto the register being written.
  always_comb begin
    dec_s = 5'b00000;
    case (M68K_ADDR[6:4])
      3'b010:  dec_s[W_SLOTS] = 1'b1;
      3'b011:  dec_s[W_LATCH] = 1'b1;
      3'b100:  dec_s[W_LDATA] = 1'b1;
      3'b101:  dec_s[W_MAN]   = 1'b1;
      3'b110:  dec_s[W_CMD]   = 1'b1;
      default: dec_s          = 5'b00000;
    endcase
  end

  assign wr_vec_s = wr_s ? dec_s : 5'b00000;

  // Slot-select and LED registers, updated on the edge that ends the write pulse.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      slots_r     <= 3'd0;
      led_latch_r <= 3'd0;
      led_data_r  <= 8'd0;
    end else begin
      if (wr_vec_s[W_SLOTS]) begin
        slots_r <= M68K_DATA_IN[2:0];
      end
      if (wr_vec_s[W_LATCH]) begin
        led_latch_r <= M68K_DATA_IN[5:3];
      end
      if (wr_vec_s[W_LDATA]) begin
        led_data_r <= M68K_DATA_IN;
      end
    end
  end

  // RTC command engine: IDLE mirrors the manual pin register; a command write
  // shifts four bits (low phase then high phase each) and finishes with a strobe.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      man_r     <= 3'b000;
      cmd_r     <= 4'd0;
      bit_idx_r <= 2'd0;
      div_r     <= '0;
      din_r     <= 1'b0;
      clk_r     <= 1'b0;
      strobe_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_vec_s[W_CMD]) begin
            state_r   <= ST_BIT_LO;
            cmd_r     <= M68K_DATA_IN[3:0];
            bit_idx_r <= 2'd0;
            div_r     <= '0;
            din_r     <= M68K_DATA_IN[0];
            clk_r     <= 1'b0;
            strobe_r  <= 1'b0;
            busy_r    <= 1'b1;
          end else if (wr_vec_s[W_MAN]) begin
            man_r                       <= M68K_DATA_IN[2:0];
            {strobe_r, clk_r, din_r}    <= M68K_DATA_IN[2:0];
          end else begin
            {strobe_r, clk_r, din_r}    <= man_r;
          end
        end
        ST_BIT_LO: begin
          if (div_r == DIV_LAST) begin
            div_r   <= '0;
            clk_r   <= 1'b1;
            state_r <= ST_BIT_HI;
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        ST_BIT_HI: begin
          if (div_r == DIV_LAST) begin
            div_r <= '0;
            clk_r <= 1'b0;
            if (bit_idx_r == 2'd3) begin
              din_r    <= 1'b0;
              strobe_r <= 1'b1;
              state_r  <= ST_STROBE;
            end else begin
              bit_idx_r <= bit_idx_r + 2'd1;
              din_r     <= cmd_r[bit_idx_r + 2'd1];
              state_r   <= ST_BIT_LO;
            end
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        ST_STROBE: begin
          if (div_r == DIV_LAST) begin
            div_r     <= '0;
            bit_idx_r <= 2'd0;
            man_r     <= 3'b000;
            din_r     <= 1'b0;
            clk_r     <= 1'b0;
            strobe_r  <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bit_idx_r <= 2'd0;
          div_r     <= '0;
          din_r     <= 1'b0;
          clk_r     <= 1'b0;
          strobe_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Read mux: the DIP/systype read has priority over the status read.
  always_comb begin
    rd_oe_s = ~nDIPRD0 | ~nDIPRD1;
    if (!nDIPRD0) begin
      rd_data_s = M68K_ADDR[7] ? 8'h80 : DIPSW;
    end else if (!nDIPRD1) begin
      rd_data_s = {RTC_DOUT, RTC_TP, busy_r, 5'b11111};
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Active-low one-hot slot select; out-of-range slot numbers select nothing.
  always_comb begin
    nslot_s = '1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (SYSTEMB && (slots_r == 3'(i))) begin
        nslot_s[i] = 1'b0;
      end else begin
        nslot_s[i] = 1'b1;
      end
    end
  end

  assign M68K_DATA_OUT = rd_data_s;
  assign M68K_DATA_OE  = rd_oe_s;
  assign nSLOT         = nslot_s;
  assign SLOT_SEL      = SYSTEMB ? slots_r : 3'd0;
  assign LED_LATCH     = led_latch_r;
  assign LED_DATA      = led_data_r;
  assign RTC_DIN       = din_r;
  assign RTC_CLK       = clk_r;
  assign RTC_STROBE    = strobe_r;
  assign RTC_BUSY      = busy_r;

endmodule

// File: tb/tb_neo_f0_sync.sv
`timescale 1ns/1ps
// Self-checking bench for neo_f0_sync: directed and randomised writes, reads
// and RTC commands, compared against a behavioural model of the block.
module tb_neo_f0_sync;

  localparam int NSL = 6;
  localparam int DIV = 2;

  logic           clk = 1'b0;
  logic           RESET;
  logic           nDIPRD0, nDIPRD1, nBITWD0;
  logic [7:4]     M68K_ADDR;
  logic [7:0]     M68K_DATA_IN;
  logic [7:0]     M68K_DATA_OUT;
  logic           M68K_DATA_OE;
  logic [7:0]     DIPSW;
  logic           SYSTEMB;
  logic [NSL-1:0] nSLOT;
  logic [2:0]     SLOT_SEL, LED_LATCH;
  logic [7:0]     LED_DATA;
  logic           RTC_DOUT, RTC_TP;
  logic           RTC_DIN, RTC_CLK, RTC_STROBE, RTC_BUSY;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  neo_f0_sync #(.NUM_SLOTS(NSL), .RTC_DIV(DIV)) dut (
    .CLK_24M(clk), .RESET(RESET),
    .nDIPRD0(nDIPRD0), .nDIPRD1(nDIPRD1), .nBITWD0(nBITWD0),
    .M68K_ADDR(M68K_ADDR), .M68K_DATA_IN(M68K_DATA_IN),
    .M68K_DATA_OUT(M68K_DATA_OUT), .M68K_DATA_OE(M68K_DATA_OE),
    .DIPSW(DIPSW), .SYSTEMB(SYSTEMB), .nSLOT(nSLOT), .SLOT_SEL(SLOT_SEL),
    .LED_LATCH(LED_LATCH), .LED_DATA(LED_DATA),
    .RTC_DOUT(RTC_DOUT), .RTC_TP(RTC_TP),
    .RTC_DIN(RTC_DIN), .RTC_CLK(RTC_CLK), .RTC_STROBE(RTC_STROBE),
    .RTC_BUSY(RTC_BUSY)
  );

  always #5 clk = ~clk;

  // free-running cycle counter used as the time base of the RTC model
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // expected active-low slot select
  function automatic logic [NSL-1:0] exp_nslot(input logic [2:0] s, input logic sysb);
    logic [NSL-1:0] r;
    r = '1;
    if (sysb && (int'(s) < NSL)) r = ~(NSL'(1) << s);
    return r;
  endfunction

  // expected {BUSY,STROBE,CLK,DIN} t cycles after the engine left idle
  function automatic logic [3:0] rtc_exp(input logic [3:0] c, input int t);
    int b;
    logic hi;
    if (t < 8 * DIV) begin
      b  = t / (2 * DIV);
      hi = ((t % (2 * DIV)) >= DIV);
      return {1'b1, 1'b0, hi, c[b]};
    end else if (t < 9 * DIV) begin
      return 4'b1100;
    end else begin
      return 4'b0000;
    end
  endfunction

  // bit-write cycle; returns #1 after the edge on which the write takes effect
  task automatic bwrite(input logic [3:0] a, input logic [7:0] d);
    repeat (3) @(negedge clk);
    M68K_ADDR    = a;
    M68K_DATA_IN = d;
    nBITWD0      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nBITWD0 = 1'b1;
  endtask

  // start a command and follow every cycle of it, including a status read
  task automatic run_cmd(input logic [3:0] c);
    int start;
    logic [3:0] e;
    logic [3:0] hi_bits;
    hi_bits = 4'($urandom);
    bwrite(4'h6, {hi_bits, c});
    start   = cyc;
    nDIPRD1 = 1'b0;
    for (int k = 0; k <= 9 * DIV; k++) begin
      RTC_DOUT = 1'($urandom);
      RTC_TP   = 1'($urandom);
      #1;
      e = rtc_exp(c, cyc - start);
      check("rtc_pins", {RTC_BUSY, RTC_STROBE, RTC_CLK, RTC_DIN}, e);
      check("stat_rd", M68K_DATA_OUT, {RTC_DOUT, RTC_TP, e[3], 5'b11111});
      @(posedge clk);
      #1;
    end
    nDIPRD1 = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] m_slots;
    logic [2:0] m_latch;
    logic [7:0] m_led;
    logic [3:0] c;
    int start;

    RESET = 1'b1; nDIPRD0 = 1'b1; nDIPRD1 = 1'b1; nBITWD0 = 1'b1;
    M68K_ADDR = 4'h0; M68K_DATA_IN = 8'h00; DIPSW = 8'h00; SYSTEMB = 1'b1;
    RTC_DOUT = 1'b0; RTC_TP = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) RESET = 1'b0;
    @(posedge clk); #1;

    // reset state
    check("rst_nslot", nSLOT, 6'b111110);
    check("rst_slotsel", SLOT_SEL, 3'd0);
    check("rst_led", LED_DATA, 8'h00);
    check("rst_latch", LED_LATCH, 3'd0);
    check("rst_rtc", {RTC_BUSY, RTC_STROBE, RTC_CLK, RTC_DIN}, 4'b0000);
    check("rst_oe", M68K_DATA_OE, 1'b0);

    // slot select directed
    bwrite(4'h2, 8'h05);
    check("slot5_sel", SLOT_SEL, 3'd5);
    check("slot5_n", nSLOT, 6'b011111);
    bwrite(4'h2, 8'h07);
    check("slot7_sel", SLOT_SEL, 3'd7);
    check("slot7_n", nSLOT, 6'b111111);
    SYSTEMB = 1'b0; #1;
    check("sysb0_sel", SLOT_SEL, 3'd0);
    check("sysb0_n", nSLOT, 6'b111111);
    m_slots = 3'd7;

    // slot select randomised
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      bwrite(4'h2, d);
      m_slots = d[2:0];
      SYSTEMB = 1'($urandom); #1;
      check("rslot_sel", SLOT_SEL, SYSTEMB ? m_slots : 3'd0);
      check("rslot_n", nSLOT, exp_nslot(m_slots, SYSTEMB));
    end
    SYSTEMB = 1'b1;

    // LEDs
    bwrite(4'h3, 8'h28);
    check("latch", LED_LATCH, 3'b101);
    bwrite(4'h4, 8'hA5);
    check("led", LED_DATA, 8'hA5);
    m_latch = 3'b101; m_led = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      bwrite(4'h3, d); m_latch = d[5:3];
      d = 8'($urandom);
      bwrite(((i % 2) == 0) ? 4'h4 : 4'hC, d); m_led = d;
      check("rlatch", LED_LATCH, m_latch);
      check("rled", LED_DATA, m_led);
    end

    // unmapped addresses change nothing
    bwrite(4'h0, 8'hFF);
    bwrite(4'h7, 8'hFF);
    check("unmap_led", LED_DATA, m_led);
    check("unmap_latch", LED_LATCH, m_latch);
    check("unmap_slot", SLOT_SEL, m_slots);
    check("unmap_rtc", {RTC_BUSY, RTC_STROBE, RTC_CLK, RTC_DIN}, 4'b0000);

    // reads
    DIPSW = 8'h3C; M68K_ADDR = 4'h0; nDIPRD0 = 1'b0; #1;
    check("dip_rd", M68K_DATA_OUT, 8'h3C);
    check("dip_oe", M68K_DATA_OE, 1'b1);
    M68K_ADDR = 4'h8; #1;
    check("systype_rd", M68K_DATA_OUT, 8'h80);
    M68K_ADDR = 4'h0; nDIPRD1 = 1'b0; #1;
    check("both_rd", M68K_DATA_OUT, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      DIPSW = 8'($urandom); #1;
      check("rdip_rd", M68K_DATA_OUT, DIPSW);
    end
    nDIPRD0 = 1'b1; RTC_DOUT = 1'b1; RTC_TP = 1'b0; #1;
    check("stat_idle", M68K_DATA_OUT, 8'b10011111);
    nDIPRD1 = 1'b1; #1;
    check("none_oe", M68K_DATA_OE, 1'b0);
    check("none_rd", M68K_DATA_OUT, 8'h00);

    // manual RTC pins, then a command clears them on completion
    bwrite(4'h5, 8'h05);
    check("man_pins", {RTC_BUSY, RTC_STROBE, RTC_CLK, RTC_DIN}, 4'b0101);
    run_cmd(4'h9);
    for (int i = 0; i < 2; i++) begin
      c = 4'($urandom);
      run_cmd(c);
    end

    // writes during busy are ignored, then reset mid-bit
    c = 4'($urandom);
    bwrite(4'h6, {4'h0, c});
    start = cyc;
    bwrite(4'h5, 8'h07);
    check("busy_man", {RTC_BUSY, RTC_STROBE, RTC_CLK, RTC_DIN}, rtc_exp(c, cyc - start));
    bwrite(4'h6, 8'h03);
    check("busy_cmd", {RTC_BUSY, RTC_STROBE, RTC_CLK, RTC_DIN}, rtc_exp(c, cyc - start));
    @(negedge clk) RESET = 1'b1;
    @(posedge clk); #1;
    check("rstmid_rtc", {RTC_BUSY, RTC_STROBE, RTC_CLK, RTC_DIN}, 4'b0000);
    check("rstmid_nslot", nSLOT, 6'b111110);
    check("rstmid_led", LED_DATA, 8'h00);
    @(negedge clk) RESET = 1'b0;
    repeat (2 * DIV + 2) @(posedge clk);
    #1;
    check("no_resume", {RTC_BUSY, RTC_STROBE, RTC_CLK, RTC_DIN}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/neo_f0_sync.md
# neo_f0_sync

Synchronous, parametrised F0 system I/O block for the NeoGeo simulation model. Decodes 68k byte writes in the $38xxx1 bit-write space into slot-select, LED and RTC-control registers, drives DIP-switch/status reads, and adds a hardware RTC command engine that serialises a 4-bit uPD4990 command with strobe, so the BIOS no longer has to bit-bang it. Sits between the 68k bus decode (nDIPRD0/nDIPRD1/nBITWD0) and the slot, LED and RTC pins.

## Interface
- NUM_SLOTS, 6, number of cartridge slots decoded (1..8)
- RTC_DIV, 12, CLK_24M cycles per RTC serial half-period (>=1)
- CLK_24M  in  1  system clock; all state on rising edge
- RESET  in  1  reset; synchronous, active-high
- nDIPRD0  in  1  DIP/systype read enable, active-low
- nDIPRD1  in  1  status-A read enable, active-low
- nBITWD0  in  1  bit-write strobe, active-low, asynchronous to CLK_24M
- M68K_ADDR  in  4  address bits [7:4]
- M68K_DATA_IN  in  8  68k write data (low byte)
- M68K_DATA_OUT  out  8  read data
- M68K_DATA_OE  out  1  read data enable
- DIPSW  in  8  DIP switch levels
- SYSTEMB  in  1  multi-slot board enable
- nSLOT  out  NUM_SLOTS  one-hot active-low slot select
- SLOT_SEL  out  3  encoded slot number
- LED_LATCH  out  3  LED latch controls
- LED_DATA  out  8  LED data
- RTC_DOUT, RTC_TP  in  1 each  RTC data out, time pulse
- RTC_DIN, RTC_CLK, RTC_STROBE  out  1 each  RTC serial pins
- RTC_BUSY  out  1  command engine active

## Operation
- Write detect: nBITWD0 through 2-flop synchroniser (reset to 1); falling edge of synchronised value gives one-cycle WR pulse; M68K_ADDR and M68K_DATA_IN sampled on that cycle.
- On WR, by ADDR[6:4]: 010 SLOTS<=D[2:0]; 011 LED_LATCH<=D[5:3]; 100 LED_DATA<=D[7:0]; 101 manual RTC pins {STROBE,CLK,DIN}<=D[2:0] (ignored while RTC_BUSY); 110 start command D[3:0] (ignored while RTC_BUSY); others no effect.
- SLOT_SEL = SYSTEMB ? SLOTS : 0. nSLOT = all ones unless SYSTEMB=1 and SLOTS<NUM_SLOTS, then bit SLOTS low.
- Reads combinational: nDIPRD0 low -> ADDR[7] ? 8'h80 : DIPSW; else nDIPRD1 low -> {RTC_DOUT, RTC_TP, RTC_BUSY, 5'b11111}. nDIPRD0 wins if both low. OE = !nDIPRD0 | !nDIPRD1; DATA_OUT = 0 when OE=0.
- RTC engine FSM: IDLE -> (cmd write) BIT_LO -> BIT_HI -> BIT_LO ... -> STROBE -> IDLE. Bits sent LSB first. BIT_LO: CLK=0, DIN=cmd[i], RTC_DIV cycles. BIT_HI: CLK=1, DIN held, RTC_DIV cycles; after bit 3 go STROBE, else i+1 and BIT_LO. STROBE: CLK=0, DIN=0, STROBE=1 for RTC_DIV cycles. In IDLE pins carry manual register values.
- On entering IDLE from STROBE, manual register cleared to 000.

## Timing
- Reset values: SLOTS=0, LED_LATCH=0, LED_DATA=0, manual RTC=000, FSM IDLE, RTC_BUSY=0, bit index 0, divider 0; hence nSLOT all ones if SYSTEMB=0, else 6'b111110 (NUM_SLOTS=6).
- Register update visible on the edge after WR (3 CLK_24M edges after nBITWD0 fall, worst case 4).
- RTC_BUSY rises with FSM leaving IDLE (edge after WR), stays high exactly 9*RTC_DIV cycles, falls with FSM entering IDLE.
- RESET mid-command: next edge FSM IDLE, all RTC outputs 0, BUSY 0, no partial resume.
- nBITWD0 held low: one WR only. Glitch shorter than one cycle may be missed; not required to capture.

## Test plan
- Reset, SYSTEMB=1: nSLOT=6'b111110, LED_DATA=0, RTC pins 000, BUSY=0.
- Write $380021 data 8'h05 -> SLOT_SEL=5, nSLOT=6'b011111; write 8'h07 -> nSLOT=6'b111111; SYSTEMB=0 -> SLOT_SEL=0.
- Write $380031 8'h28 -> LED_LATCH=3'b101; write $380041 8'hA5 -> LED_DATA=8'hA5.
- RTC_DIV=2, write $380061 8'h09 -> DIN sequence 1,0,0,1 each with one 2-cycle CLK high, then STROBE high 2 cycles; BUSY high 18 cycles; nDIPRD1 read during busy -> D5=1.
- During busy, write $380051 8'h07 and $380061 8'h03 -> no pin or command change; assert RESET mid-bit -> pins 000, BUSY 0 next edge.
- nDIPRD0 low ADDR[7]=0, DIPSW=8'h3C -> 8'h3C; ADDR[7]=1 -> 8'h80; both reads low -> DIPSW path; neither -> OE=0.
